// File: rtl/truth_table_bist.sv
// Built-in self-test wrapper: walks every input code through a small combinational
// block, samples its response after a settle window and scores it against a truth table.
module truth_table_bist #(
   parameter int                   N_IN     = 3,
   parameter logic [(1<<N_IN)-1:0] EXPECTED = 8'hE2,
   parameter int                   SETTLE   = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            dut_f,
   output logic [N_IN-1:0] vec_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic            first_fail_valid,
   output logic [N_IN-1:0] first_fail_code
);

   localparam int                CNT_W       = 4;
   localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE);
   localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1'b1);
   localparam logic [N_IN-1:0]   CODE_ZERO   = {N_IN{1'b0}};
   localparam logic [N_IN-1:0]   CODE_ONE    = N_IN'(1'b1);
   localparam logic [N_IN-1:0]   LAST_CODE   = {N_IN{1'b1}};
   localparam logic [N_IN:0]     ERR_ZERO    = {(N_IN+1){1'b0}};
   localparam logic [N_IN:0]     ERR_ONE     = (N_IN+1)'(1'b1);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_RUN_WAIT   = 2'd1,
      ST_RUN_SAMPLE = 2'd2,
      ST_DONE       = 2'd3
   } state_t;

   state_t            state_r;
   state_t            phase_s;
   state_t            state_nxt_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_nxt_s;
   logic [N_IN-1:0]   vec_r;
   logic [N_IN-1:0]   vec_nxt_s;
   logic              busy_r;
   logic              busy_nxt_s;
   logic              done_r;
   logic              done_nxt_s;
   logic [N_IN:0]     err_r;
   logic [N_IN:0]     err_nxt_s;
   logic              ffv_r;
   logic              ffv_nxt_s;
   logic [N_IN-1:0]   ffc_r;
   logic [N_IN-1:0]   ffc_nxt_s;
   logic              mismatch_s;
   logic              last_code_s;

   function automatic logic expected_bit(input logic [N_IN-1:0] code);
      return EXPECTED[code];
   endfunction

   assign mismatch_s  = dut_f ^ expected_bit(vec_r);
   assign last_code_s = (vec_r == LAST_CODE);

   // Sampling phase: the final settle cycle of each vector is decoded rather than stored,
   // so every vector lasts exactly SETTLE+1 cycles, including SETTLE=0.
   always_comb begin
      phase_s = state_r;
      if ((state_r == ST_RUN_WAIT) && (cnt_r == CNT_ZERO)) begin
         phase_s = ST_RUN_SAMPLE;
      end else begin
         phase_s = state_r;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; start is honoured only when no run is in progress.
   always_comb begin
      state_nxt_s = state_r;
      case (phase_s)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nxt_s = ST_RUN_WAIT;
            end else begin
               state_nxt_s = phase_s;
            end
         end
         ST_RUN_WAIT: begin
            state_nxt_s = ST_RUN_WAIT;
         end
         ST_RUN_SAMPLE: begin
            if (last_code_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_RUN_WAIT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Output/datapath next values: vector stepping, settle timing and scoring.
   always_comb begin
      cnt_nxt_s  = cnt_r;
      vec_nxt_s  = vec_r;
      busy_nxt_s = busy_r;
      done_nxt_s = done_r;
      err_nxt_s  = err_r;
      ffv_nxt_s  = ffv_r;
      ffc_nxt_s  = ffc_r;
      case (phase_s)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               cnt_nxt_s  = SETTLE_LOAD;
               vec_nxt_s  = CODE_ZERO;
               busy_nxt_s = 1'b1;
               done_nxt_s = 1'b0;
               err_nxt_s  = ERR_ZERO;
               ffv_nxt_s  = 1'b0;
               ffc_nxt_s  = CODE_ZERO;
            end else begin
               cnt_nxt_s  = cnt_r;
            end
         end
         ST_RUN_WAIT: begin
            cnt_nxt_s = cnt_r - CNT_ONE;
         end
         ST_RUN_SAMPLE: begin
            if (mismatch_s) begin
               err_nxt_s = err_r + ERR_ONE;
               if (!ffv_r) begin
                  ffv_nxt_s = 1'b1;
                  ffc_nxt_s = vec_r;
               end else begin
                  ffc_nxt_s = ffc_r;
               end
            end else begin
               err_nxt_s = err_r;
            end
            if (last_code_s) begin
               busy_nxt_s = 1'b0;
               done_nxt_s = 1'b1;
            end else begin
               vec_nxt_s = vec_r + CODE_ONE;
               cnt_nxt_s = SETTLE_LOAD;
            end
         end
         default: begin
            cnt_nxt_s = CNT_ZERO;
         end
      endcase
   end

   // Datapath and result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r  <= CNT_ZERO;
         vec_r  <= CODE_ZERO;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         err_r  <= ERR_ZERO;
         ffv_r  <= 1'b0;
         ffc_r  <= CODE_ZERO;
      end else begin
         cnt_r  <= cnt_nxt_s;
         vec_r  <= vec_nxt_s;
         busy_r <= busy_nxt_s;
         done_r <= done_nxt_s;
         err_r  <= err_nxt_s;
         ffv_r  <= ffv_nxt_s;
         ffc_r  <= ffc_nxt_s;
      end
   end

   assign vec_out          = vec_r;
   assign busy             = busy_r;
   assign done             = done_r;
   assign err_count        = err_r;
   assign first_fail_valid = ffv_r;
   assign first_fail_code  = ffc_r;
   assign pass             = done_r & (err_r == ERR_ZERO);

endmodule

// File: tb/tb_truth_table_bist.sv
// Bench for truth_table_bist: two instances (SETTLE=2 and SETTLE=0) scored every cycle
// against a timing/arithmetic model, plus directed literal checks.
module tb_truth_table_bist;

   localparam int         NV  = 8;
   localparam logic [7:0] EXP = 8'hE2;

   logic       clk     = 1'b0;
   logic       reset   = 1'b0;
   logic       chk_en  = 1'b0;
   logic [1:0] start_s = 2'b00;
   logic [1:0] rnd_s   = 2'b00;
   logic [1:0] dutf_s;
   int         mode [2] = '{0, 0};

   logic [2:0] vec_w [2];
   logic [1:0] busy_w, done_w, pass_w, ffv_w;
   logic [3:0] err_w [2];
   logic [2:0] ffc_w [2];

   int checks = 0;
   int errors = 0;
   int edges;

   // model state per instance: run flag, edges since start, expected outputs
   logic m_run [2], m_done [2], m_ffv [2];
   int   m_t [2], m_vec [2], m_err [2], m_ffc [2];

   always #5 clk = ~clk;

   function automatic int settle_of(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   function automatic logic exp_bit(input logic [2:0] code);
      return EXP[code];
   endfunction

   // mode 0 = correct block, 1 = stuck at 0, 2 = inverted, 3 = random response
   function automatic logic drive_f(input int m, input logic [2:0] v, input logic r);
      case (m)
         0:       return exp_bit(v);
         1:       return 1'b0;
         2:       return ~exp_bit(v);
         default: return r;
      endcase
   endfunction

   assign dutf_s[0] = drive_f(mode[0], vec_w[0], rnd_s[0]);
   assign dutf_s[1] = drive_f(mode[1], vec_w[1], rnd_s[1]);

   always @(negedge clk) rnd_s <= 2'($urandom);

   truth_table_bist #(.N_IN(3), .EXPECTED(8'hE2), .SETTLE(2)) u_dut_a (
      .clk(clk), .reset(reset), .start(start_s[0]), .dut_f(dutf_s[0]),
      .vec_out(vec_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
      .err_count(err_w[0]), .first_fail_valid(ffv_w[0]), .first_fail_code(ffc_w[0]));

   truth_table_bist #(.N_IN(3), .EXPECTED(8'hE2), .SETTLE(0)) u_dut_b (
      .clk(clk), .reset(reset), .start(start_s[1]), .dut_f(dutf_s[1]),
      .vec_out(vec_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
      .err_count(err_w[1]), .first_fail_valid(ffv_w[1]), .first_fail_code(ffc_w[1]));

   task automatic check(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, idx, act, exp, $time);
      end
   endtask

   // Reference model: after edge E0+t, vector is t/(SETTLE+1); edge t with t%(SETTLE+1)==0
   // samples code t/(SETTLE+1)-1; the run ends after NV samples.
   always @(posedge clk or posedge reset) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_run[i] <= 1'b0; m_done[i] <= 1'b0; m_ffv[i] <= 1'b0;
            m_t[i] <= 0; m_vec[i] <= 0; m_err[i] <= 0; m_ffc[i] <= 0;
         end else if (!m_run[i] && start_s[i]) begin
            m_run[i] <= 1'b1; m_done[i] <= 1'b0; m_ffv[i] <= 1'b0;
            m_t[i] <= 0; m_vec[i] <= 0; m_err[i] <= 0; m_ffc[i] <= 0;
         end else if (m_run[i]) begin
            m_t[i] <= m_t[i] + 1;
            m_vec[i] <= ((m_t[i] + 1) / (settle_of(i) + 1) < NV) ?
                        (m_t[i] + 1) / (settle_of(i) + 1) : NV - 1;
            if ((m_t[i] + 1) % (settle_of(i) + 1) == 0) begin
               if (dutf_s[i] != exp_bit(3'((m_t[i] + 1) / (settle_of(i) + 1) - 1))) begin
                  m_err[i] <= m_err[i] + 1;
                  if (!m_ffv[i]) begin
                     m_ffv[i] <= 1'b1;
                     m_ffc[i] <= (m_t[i] + 1) / (settle_of(i) + 1) - 1;
                  end
               end
               if ((m_t[i] + 1) / (settle_of(i) + 1) == NV) begin
                  m_run[i]  <= 1'b0;
                  m_done[i] <= 1'b1;
               end
            end
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            check("vec_out", i, vec_w[i], m_vec[i]);
            check("busy", i, busy_w[i], m_run[i]);
            check("done", i, done_w[i], m_done[i]);
            check("pass", i, pass_w[i], (m_done[i] && m_err[i] == 0) ? 1 : 0);
            check("err_count", i, err_w[i], m_err[i]);
            check("ff_valid", i, ffv_w[i], m_ffv[i]);
            check("ff_code", i, ffc_w[i], m_ffc[i]);
         end
      end
   end

   task automatic start_run(input int i);
      @(negedge clk);
      start_s[i] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_s[i] = 1'b0;
   endtask

   // disturb: 0 none, 1 directed start pokes at E0+10 and E0+12..15, 2 random pokes
   task automatic wait_done(input int i, input int disturb, output int n);
      n = 0;
      while (!done_w[i] && n < 200) begin
         if (disturb == 1) start_s[i] = (n == 9 || (n >= 11 && n <= 14));
         else if (disturb == 2) start_s[i] = 1'($urandom_range(0, 1));
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      start_s[i] = 1'b0;
      check("done_timeout", i, done_w[i], 1);
   endtask

   initial begin
      #1 reset = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         check("rst_vec", i, vec_w[i], 0);
         check("rst_busy", i, busy_w[i], 0);
         check("rst_done", i, done_w[i], 0);
         check("rst_pass", i, pass_w[i], 0);
         check("rst_err", i, err_w[i], 0);
         check("rst_ffv", i, ffv_w[i], 0);
      end
      @(negedge clk);
      reset = 1'b0;

      // 1: correct block
      mode[0] = 0;
      start_run(0);
      wait_done(0, 0, edges);
      check("t1_latency", 0, edges, 24);
      check("t1_pass", 0, pass_w[0], 1);
      check("t1_err", 0, err_w[0], 0);
      check("t1_ffv", 0, ffv_w[0], 0);

      // 2: stuck at 0 fails codes 1,5,6,7
      mode[0] = 1;
      start_run(0);
      wait_done(0, 0, edges);
      check("t2_latency", 0, edges, 24);
      check("t2_err", 0, err_w[0], 4);
      check("t2_ffc", 0, ffc_w[0], 1);
      check("t2_ffv", 0, ffv_w[0], 1);
      check("t2_pass", 0, pass_w[0], 0);

      // 3: inverted block, then restart from DONE with the correct block
      mode[0] = 2;
      start_run(0);
      wait_done(0, 0, edges);
      check("t3_err", 0, err_w[0], 8);
      check("t3_ffc", 0, ffc_w[0], 0);
      check("t3_pass", 0, pass_w[0], 0);
      mode[0] = 0;
      start_run(0);
      check("t3_clr_err", 0, err_w[0], 0);
      check("t3_clr_ffv", 0, ffv_w[0], 0);
      check("t3_clr_done", 0, done_w[0], 0);
      check("t3_clr_busy", 0, busy_w[0], 1);
      wait_done(0, 0, edges);
      check("t3_pass2", 0, pass_w[0], 1);

      // 4: start pokes while busy are ignored
      start_run(0);
      wait_done(0, 1, edges);
      check("t4_latency", 0, edges, 24);
      check("t4_pass", 0, pass_w[0], 1);

      // 5: asynchronous reset mid-run
      start_run(0);
      edges = 0;
      while (vec_w[0] != 3'd5 && edges < 100) begin
         @(negedge clk);
         edges++;
      end
      check("t5_vec_before", 0, vec_w[0], 5);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("t5_rst_vec", 0, vec_w[0], 0);
      check("t5_rst_busy", 0, busy_w[0], 0);
      check("t5_rst_err", 0, err_w[0], 0);
      check("t5_rst_done", 0, done_w[0], 0);
      @(negedge clk);
      reset = 1'b0;
      start_run(0);
      check("t5_restart_vec", 0, vec_w[0], 0);
      wait_done(0, 0, edges);
      check("t5_latency", 0, edges, 24);
      check("t5_pass", 0, pass_w[0], 1);

      // 6: SETTLE=0 instance samples every cycle
      mode[1] = 0;
      start_run(1);
      wait_done(1, 0, edges);
      check("t6_latency", 1, edges, 8);
      check("t6_pass", 1, pass_w[1], 1);

      // randomized responses and start pokes on both instances
      for (int r = 0; r < 8; r++) begin
         mode[r % 2] = $urandom_range(0, 3);
         start_run(r % 2);
         wait_done(r % 2, 2, edges);
         check("rand_latency", r % 2, edges, NV * (settle_of(r % 2) + 1));
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

endmodule

// File: doc/truth_table_bist.md
Name: truth_table_bist

Overview:
Self-checking stimulus/response stage wrapped around a small combinational block such as the 3-input `Combinational_Logic` (A,B,C -> F).
- Upstream role: drives every input code 0..2^N_IN-1 onto the block's inputs, in ascending order.
- Downstream role: samples the block's output after a settle window and compares it against a parameterised truth table.
- Reports: mismatch count, first failing code, done/pass flags.
- Serves as the synthesizable replacement for hand-written per-vector testbenches.

Parameters:
N_IN, 3, number of DUT inputs; vec_out[N_IN-1] maps to A (MSB), vec_out[0] maps to C.
EXPECTED, 8'hE2, expected truth table, width 2^N_IN; bit i is the expected F for input code i (bit 1 = 1, i.e. ABC=001 -> F=1).
SETTLE, 2, idle cycles between applying a vector and sampling; range 0..15.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high; clears all state immediately.
start  input  1  run request; sampled only in IDLE or DONE.
dut_f  input  1  DUT output under test.
vec_out  output  N_IN  input code driven to the DUT, {A,B,C}.
busy  output  1  high while a run is in progress.
done  output  1  high from run completion until the next start or reset.
pass  output  1  equals done AND (err_count == 0).
err_count  output  N_IN+1  number of mismatching codes; maximum 2^N_IN, so it cannot overflow.
first_fail_valid  output  1  at least one mismatch has been seen in this run.
first_fail_code  output  N_IN  code of the first mismatch; held until the next start.

Behaviour:
- Reset (asynchronous, active-high, effective at any time including mid-run):
  - state=IDLE.
  - vec_out, busy, done, pass, err_count, first_fail_valid, first_fail_code all 0.
  - The settle counter is cleared.
- States: IDLE, RUN_WAIT, RUN_SAMPLE, DONE.
- IDLE or DONE with start=1 at edge E0:
  - Next state is RUN_WAIT.
  - vec_out=0, busy=1, done=0.
  - err_count, first_fail_valid and first_fail_code are cleared.
  - Settle counter loads SETTLE.
- RUN_WAIT:
  - Counter decrements each cycle.
  - When the counter is 0, the next state is RUN_SAMPLE.
  - If SETTLE=0, RUN_WAIT lasts 1 cycle before RUN_SAMPLE.
  - Each vector is held for exactly SETTLE+1 cycles.
- RUN_SAMPLE:
  - dut_f is compared with EXPECTED[vec_out] on this edge.
  - On mismatch: err_count increments. If first_fail_valid=0, first_fail_code takes vec_out and first_fail_valid is set to 1.
  - If vec_out == 2^N_IN-1: next state is DONE, busy=0, done=1, and vec_out holds its last value.
  - Otherwise: vec_out increments, the counter reloads SETTLE, and the next state is RUN_WAIT.
- Timing: samples occur at edges E0+k*(SETTLE+1) for k=1..2^N_IN. done rises after edge E0+2^N_IN*(SETTLE+1), which is 24 edges for the defaults.
- start while busy is ignored; there is no restart and no abort.
- start held high in DONE starts a new run on the next edge.
- dut_f is sampled only in RUN_SAMPLE; its value at all other times has no effect.
- err_count, first_fail_valid and first_fail_code remain stable throughout DONE.
- pass is combinational from done and err_count, so it is never 1 while busy.

Test Plan:
1. Behavioural model with dut_f = EXPECTED[vec_out] (default parameters); pulse start -> vec_out steps 0..7, each value held 3 cycles. done=1 and pass=1 at E0+24, err_count=0, first_fail_valid=0.
2. dut_f stuck at 0 -> done at E0+24 with err_count=4 (codes 1,5,6,7), first_fail_code=3'b001, first_fail_valid=1, pass=0.
3. dut_f = ~EXPECTED[vec_out] -> err_count=8, first_fail_code=0, pass=0. Then a start from DONE -> counters clear on the next edge and a fresh run with the correct model ends with pass=1.
4. start pulsed again at E0+10 and held high E0+12..E0+15 -> ignored; done still rises at E0+24 and the vec_out sequence is undisturbed.
5. reset asserted asynchronously mid-cycle while vec_out=5 -> all outputs 0 immediately, without waiting for a clock edge. A subsequent start runs the full 8 vectors from code 0.
6. Instance with SETTLE=0 and the correct model -> one sample per cycle, done at E0+8, pass=1.
